// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: condition codes, flag bit positions, FSM encoding.
package pc_seq_pkg;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_BLTZ = 3'b001;
  localparam logic [2:0] COND_BZ   = 3'b010;
  localparam logic [2:0] COND_BNZ  = 3'b011;
  localparam logic [2:0] COND_BCY  = 3'b100;
  localparam logic [2:0] COND_BNCY = 3'b101;
  localparam logic [2:0] COND_BR   = 3'b110;
  localparam logic [2:0] COND_HALT = 3'b111;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch decision: condition code against the registered {carry,zero,sign} flags.
// Zero latency; no flow control. HALT and NONE never report a taken branch.
module branch_resolve
  import pc_seq_pkg::*;
(
  input  logic [2:0] condition,
  input  logic [2:0] flags,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (condition)
      COND_BLTZ: take = flags[FLAG_SIGN];
      COND_BZ:   take = flags[FLAG_ZERO];
      COND_BNZ:  take = ~flags[FLAG_ZERO];
      COND_BCY:  take = flags[FLAG_CARRY];
      COND_BNCY: take = ~flags[FLAG_CARRY];
      COND_BR:   take = 1'b1;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, flag register and branch/halt sequencing; all outputs registered, one-cycle update.
// stall freezes every register (HALT already frozen); optional call/return link via PC_SEQ_LINK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int unsigned     PC_INC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          instr_valid,
  input  logic [2:0]    condition,
  input  logic [AW-1:0] target,
  input  logic          flags_we,
  input  logic [2:0]    flags_in,
  output logic [AW-1:0] pc,
  output logic [2:0]    flags,
  output logic          taken,
  output logic          flush,
  output logic          halted
`ifdef PC_SEQ_LINK_EN
  ,
  input  logic          link_we,
  input  logic          ret,
  output logic [AW-1:0] link
`endif
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] pc_d;
  logic [2:0]    flags_d;
  logic          taken_d, flush_d, halted_d;
  logic [AW-1:0] pc_inc;
  logic          take;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  assign pc_inc = pc + AW'(PC_INC);

  // Decision uses the registered flags; a same-cycle flags_we is deliberately not forwarded.
  branch_resolve u_branch_resolve (
    .condition (condition),
    .flags     (flags),
    .take      (take)
  );

`ifdef PC_SEQ_LINK_EN
  logic [AW-1:0] link_d;
  assign redirect    = ret | take;
  assign redirect_pc = ret ? link : target;
`else
  assign redirect    = take;
  assign redirect_pc = target;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    flags_d  = flags;
    taken_d  = taken;
    flush_d  = flush;
    halted_d = halted;
`ifdef PC_SEQ_LINK_EN
    link_d   = link;
`endif
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (flags_we) flags_d = flags_in;
          pc_d    = pc_inc;
          taken_d = 1'b0;
          flush_d = 1'b0;
          if (instr_valid) begin
            if (redirect) begin
              pc_d    = redirect_pc;
              taken_d = 1'b1;
              flush_d = 1'b1;
              state_d = FLUSH;
`ifdef PC_SEQ_LINK_EN
              if (!ret && link_we) link_d = pc_inc;
`endif
            end else if (condition == COND_HALT) begin
              pc_d     = pc;
              halted_d = 1'b1;
              state_d  = HALT;
            end
          end
        end
        FLUSH: begin
          // The instruction in this slot is the squashed wrong-path fetch.
          if (flags_we) flags_d = flags_in;
          pc_d    = pc_inc;
          taken_d = 1'b0;
          flush_d = 1'b0;
          state_d = RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc      <= RESET_PC;
      flags   <= 3'b000;
      taken   <= 1'b0;
      flush   <= 1'b0;
      halted  <= 1'b0;
`ifdef PC_SEQ_LINK_EN
      link    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      flags   <= flags_d;
      taken   <= taken_d;
      flush   <= flush_d;
      halted  <= halted_d;
`ifdef PC_SEQ_LINK_EN
      link    <= link_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build, link feature disabled).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, instr_valid, flags_we;
  logic [2:0]  condition, flags_in;
  logic [31:0] target;
  logic [31:0] pc;
  logic [2:0]  flags;
  logic        taken, flush, halted;

  int checks = 0;
  int errors = 0;

  logic [2:0]  cv [8] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b100, 3'b100, 3'b101, 3'b010};
  logic [2:0]  fv [8] = '{3'b001, 3'b110, 3'b000, 3'b010, 3'b100, 3'b011, 3'b000, 3'b101};
  logic        tv [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0};

  pc_sequencer #(.AW(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .instr_valid (instr_valid),
    .condition   (condition),
    .target      (target),
    .flags_we    (flags_we),
    .flags_in    (flags_in),
    .pc          (pc),
    .flags       (flags),
    .taken       (taken),
    .flush       (flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; instr_valid = 1'b1; condition = 3'b110;
    target = 32'hDEAD_BEEC; flags_we = 1'b1; flags_in = 3'b111;
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags); end
    checks++; if ({taken, flush, halted} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b exp 000", {taken, flush, halted}); end
  endtask

  task automatic test_sequential();
    rst = 1'b0; stall = 1'b0; flags_we = 1'b0; flags_in = 3'b000;
    instr_valid = 1'b1; condition = 3'b000; target = 32'h0;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_pc0 got %h exp 0", pc); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_bz_taken();
    instr_valid = 1'b0; flags_we = 1'b1; flags_in = 3'b010;
    step();
    checks++; if (pc !== 32'd16 || flags !== 3'b010) begin errors++; $display("FAIL bz_setup pc %h flags %b exp 10/010", pc, flags); end
    flags_we = 1'b0; instr_valid = 1'b1; condition = 3'b010; target = 32'h100;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL bz_pc got %h exp 100", pc); end
    checks++; if ({taken, flush} !== 2'b11) begin errors++; $display("FAIL bz_taken_flush got %b exp 11", {taken, flush}); end
    condition = 3'b110; target = 32'h200;
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL bz_flush_pc got %h exp 104", pc); end
    checks++; if ({taken, flush} !== 2'b00) begin errors++; $display("FAIL bz_flush_clear got %b exp 00", {taken, flush}); end
    condition = 3'b000;
    step();
    checks++; if (pc !== 32'h108) begin errors++; $display("FAIL bz_after got %h exp 108", pc); end
  endtask

  task automatic test_bncy_not_taken();
    instr_valid = 1'b0; flags_we = 1'b1; flags_in = 3'b100;
    step();
    checks++; if (pc !== 32'h10C || flags !== 3'b100) begin errors++; $display("FAIL bncy_setup pc %h flags %b exp 10c/100", pc, flags); end
    instr_valid = 1'b1; condition = 3'b101; target = 32'h300; flags_in = 3'b000;
    step();
    checks++; if (pc !== 32'h110) begin errors++; $display("FAIL bncy_pc got %h exp 110", pc); end
    checks++; if (taken !== 1'b0 || flags !== 3'b000) begin errors++; $display("FAIL bncy_state taken %b flags %b exp 0/000", taken, flags); end
    flags_we = 1'b0;
  endtask

  task automatic test_stall_flush();
    instr_valid = 1'b1; condition = 3'b110; target = 32'h400;
    step();
    checks++; if (pc !== 32'h400 || flush !== 1'b1) begin errors++; $display("FAIL stl_branch pc %h flush %b exp 400/1", pc, flush); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h400 || {taken, flush} !== 2'b11) begin errors++; $display("FAIL stl_hold%0d pc %h tf %b exp 400/11", i, pc, {taken, flush}); end
    end
    stall = 1'b0; target = 32'h500;
    step();
    checks++; if (pc !== 32'h404 || flush !== 1'b0) begin errors++; $display("FAIL stl_release pc %h flush %b exp 404/0", pc, flush); end
    condition = 3'b000;
    step();
    checks++; if (pc !== 32'h408) begin errors++; $display("FAIL stl_run got %h exp 408", pc); end
  endtask

  task automatic test_halt_wrap();
    condition = 3'b111;
    step();
    checks++; if (halted !== 1'b1 || pc !== 32'h408) begin errors++; $display("FAIL halt_enter halted %b pc %h exp 1/408", halted, pc); end
    condition = 3'b110; target = 32'h800; flags_we = 1'b1; flags_in = 3'b111;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step();
      checks++; if (pc !== 32'h408 || halted !== 1'b1 || flags !== 3'b000) begin errors++; $display("FAIL halt_hold%0d pc %h halted %b flags %b", i, pc, halted, flags); end
    end
    rst = 1'b1; stall = 1'b1;
    step();
    checks++; if (pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL halt_rst pc %h halted %b exp 0/0", pc, halted); end
    rst = 1'b0; stall = 1'b0; flags_we = 1'b0; target = 32'hFFFF_FFF8;
    step();
    checks++; if (pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_branch got %h exp fffffff8", pc); end
    condition = 3'b000;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_max got %h exp fffffffc", pc); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", pc); end
    condition = 3'b110; target = 32'h40;
    step();
    rst = 1'b1;
    step();
    checks++; if (pc !== 32'h0 || {taken, flush} !== 2'b00) begin errors++; $display("FAIL rst_midflush pc %h tf %b exp 0/00", pc, {taken, flush}); end
    rst = 1'b0;
  endtask

  task automatic test_cond_table();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; flags_we = 1'b0;
    step();
    rst = 1'b0; exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1'b0; flags_we = 1'b1; flags_in = fv[i];
      step(); exp_pc = exp_pc + 32'd4;
      checks++; if (flags !== fv[i]) begin errors++; $display("FAIL cond%0d_flags got %b exp %b", i, flags, fv[i]); end
      tgt = 32'h1000 + 32'(i * 256);
      flags_we = 1'b0; instr_valid = 1'b1; condition = cv[i]; target = tgt;
      step(); exp_pc = tv[i] ? tgt : exp_pc + 32'd4;
      checks++; if (pc !== exp_pc || taken !== tv[i]) begin errors++; $display("FAIL cond%0d pc %h taken %b exp %h/%b", i, pc, taken, exp_pc, tv[i]); end
      instr_valid = 1'b0;
      step(); exp_pc = exp_pc + 32'd4;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL cond%0d_next got %h exp %h", i, pc, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bz_taken();
    test_bncy_not_taken();
    test_stall_flush();
    test_halt_wrap();
    test_cond_table();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
